mem_burst_ctrl: RTL and testbench
=================================

# mem_burst_ctrl

Burst initiator for a single-port synchronous SRAM (`we`/`ce`/`addr`/`din`/`dout`, write when `we&ce`, registered read of one cycle when `ce&!we`, `dout` held while `ce` low). Accepts one burst command at a time and either streams write data into consecutive addresses or streams read data out with valid/ready backpressure. Sits between accelerator datapaths (tile loaders/storers) and each scratchpad instance.

## Interface
- `ADDR_WIDTH`, 8, SRAM address width.
- `DATA_WIDTH`, 16, SRAM word width.
- `LEN_WIDTH`, ADDR_WIDTH+1, burst length field width (max burst = 2^ADDR_WIDTH words).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_write`  in  1  1 = write burst, 0 = read burst.
- `cmd_addr`  in  ADDR_WIDTH  base address.
- `cmd_len`  in  LEN_WIDTH  word count; 0 = empty burst.
- `wr_valid` / `wr_ready` / `wr_data`  in / out / in  1/1/DATA_WIDTH  write stream.
- `rd_valid` / `rd_ready` / `rd_data`  out / in / out  1/1/DATA_WIDTH  read stream.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse at burst completion.
- `mem_ce`, `mem_we`  out  1  SRAM strobes.
- `mem_addr`  out  ADDR_WIDTH; `mem_din`  out  DATA_WIDTH; `mem_dout`  in  DATA_WIDTH.

## Operation
- States: IDLE, WRITE, READ, DONE.
- IDLE: `cmd_ready`=1; on `cmd_valid&cmd_ready` latch addr, len, direction; len 0 -> DONE, else WRITE or READ.
- WRITE: `wr_ready`=1; each `wr_valid` cycle drives `mem_ce`=`mem_we`=1, `mem_addr`=current addr, `mem_din`=`wr_data` combinationally; addr+1, remaining-1. Last word -> DONE.
- READ: issue a read (`mem_ce`=1, `mem_we`=0) when issued < len and `fifo_count + inflight - pop < 2` (pop = `rd_valid&rd_ready`). `mem_dout` is pushed into a 2-entry FIFO in the cycle after issue. `rd_valid` = FIFO non-empty, `rd_data` = FIFO head. When all len words have been popped -> DONE.
- DONE: `done`=1 for exactly one cycle, `busy`=1, `cmd_ready`=0; -> IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH (0xFF+1 = 0x00); no error on wrap.
- `cmd_valid` outside IDLE is ignored. `wr_ready`=0 outside WRITE. `mem_ce`=0 whenever no access occurs.
- Reset (at any time, including mid-burst): state -> IDLE, FIFO and inflight flag cleared, no `done` pulse, in-flight read data discarded.

## Timing
- While `rst` is high and in the first cycle after release, every output is 0 except `cmd_ready`, which is 0 during reset and 1 from the first cycle after release.
- Read: command accepted in cycle 0; first `mem_ce` in cycle 1; data captured at the end of cycle 2; `rd_valid` in cycle 3. With `rd_ready` held high, throughput is one word per cycle. `done` is asserted the cycle after the last pop.
- Write: command accepted in cycle 0; `wr_ready` high from cycle 1; one word per cycle; `done` is asserted the cycle after the last write handshake.
- Backpressure: FIFO never overflows; at most 2 words are buffered plus in flight; `rd_data` is stable while `rd_valid&!rd_ready`.
- A len-0 command produces `done` in cycle 1 with no SRAM access.

## Structure
- Package `mem_ctrl_pkg`: state enum (IDLE/WRITE/READ/DONE), FIFO depth constant 2.
- Sub-module `mem_rd_fifo`: 2-entry synchronous FIFO (push, pop, count, head) with synchronous reset.
- Top: FSM, address/remaining/issued counters, inflight flag.

## Test plan
- Write len 4 at 0x10 with data 0xA000..0xA003, `wr_valid` always high -> 4 consecutive `mem_we&mem_ce` at addr 0x10..0x13; `done` in cycle 5.
- Read back len 4 at 0x10, `rd_ready`=1 -> `rd_valid` in cycles 3..6 with data 0xA000..0xA003; `done` in cycle 7.
- Read len 8 with `rd_ready` toggling 1/0 -> all 8 words in order, no loss or duplication, never more than 2 words buffered, `rd_data` stable while stalled.
- Write then read len 4 at 0xFE -> addresses 0xFE, 0xFF, 0x00, 0x01; data matches.
- len 0 command -> `done` in cycle 1, `mem_ce` never asserted; `cmd_valid` asserted during a burst -> ignored.
- Assert `rst` in the middle of a read of len 8 -> state returns to IDLE, `rd_valid`=0, no `done` pulse; a subsequent read of len 2 completes correctly.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types for the scratchpad burst controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/mem_rd_fifo.sv
// mem_rd_fifo: two-entry read-return buffer for the burst controller.
module mem_rd_fifo
  import mem_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             wp;
  logic             rp;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rp];

endmodule

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: single-command burst initiator for a scratchpad SRAM.
module mem_burst_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_ce,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  len;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [LEN_WIDTH-1:0]  issued;
  logic                  inflight;
  logic                  cmd_fire;
  logic                  wr_fire;
  logic                  issue;
  logic                  pop;
  logic [1:0]            count;
  logic [2:0]            occ;
  logic [DATA_WIDTH-1:0] head;

  assign cmd_fire = (state == IDLE) && cmd_valid;
  assign wr_fire  = !rst && (state == WRITE) && wr_valid;
  assign pop      = !rst && (count != 2'd0) && rd_ready;

  // slots committed after this edge: buffered + returning - leaving
  assign occ   = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue = !rst && (state == READ) && (issued < len)
                 && (occ < 3'd2);

  mem_rd_fifo #(
    .WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .din  (mem_dout),
    .pop  (pop),
    .count(count),
    .head (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      len       <= '0;
      remaining <= '0;
      issued    <= '0;
      inflight  <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (cmd_fire) begin
        addr      <= cmd_addr;
        len       <= cmd_len;
        remaining <= cmd_len;
        issued    <= '0;
      end else begin
        if (wr_fire || issue) addr <= addr + ADDR_WIDTH'(1);
        if (wr_fire || pop) remaining <= remaining - LEN_WIDTH'(1);
        if (issue) issued <= issued + LEN_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = '0;
    busy      = 1'b0;
    done      = 1'b0;
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) state_nxt = DONE;
          else if (cmd_write) state_nxt = WRITE;
          else state_nxt = READ;
        end
      end
      WRITE: if (wr_fire && remaining == LEN_WIDTH'(1)) state_nxt = DONE;
      READ:  if (pop && remaining == LEN_WIDTH'(1)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
    endcase
    if (!rst) begin
      cmd_ready = (state == IDLE);
      busy      = (state != IDLE);
      done      = (state == DONE);
      wr_ready  = (state == WRITE);
      rd_valid  = (count != 2'd0);
      if (rd_valid) rd_data = head;
      if (wr_fire) begin
        mem_ce   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = addr;
        mem_din  = wr_data;
      end else if (issue) begin
        mem_ce   = 1'b1;
        mem_addr = addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: scoreboard bench for mem_burst_ctrl with an SRAM model.
module tb_mem_burst_ctrl;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int LW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          mem_ce;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  always #5 clk = ~clk;

  mem_burst_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .mem_ce   (mem_ce),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  logic [DW-1:0] sram   [256];
  logic [DW-1:0] shadow [256];

  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) sram[mem_addr] <= mem_din;
      else mem_dout <= sram[mem_addr];
    end
  end

  logic [23:0] wq  [$];
  logic [15:0] rq  [$];
  logic [7:0]  raq [$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int cyc0 = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int first_rv = -1;
  int ce_cnt = 0;
  int iss_cnt = 0;
  int pop_cnt = 0;
  int rr_mode = 0;
  logic [DW-1:0] prev_data = '0;
  bit prev_stall = 1'b0;
  logic [23:0] e;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ready pattern: 0 = always, 1 = alternate, 2 = never
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       rd_ready = 1'b1;
      1:       rd_ready = ~rd_ready;
      default: rd_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      check("rst_outs", {25'b0, cmd_ready, wr_ready, rd_valid, busy,
                         done, mem_ce, mem_we}, 32'd0);
      check("rst_bus", {mem_addr, mem_din}, 32'd0);
      check("rst_rdata", {16'b0, rd_data}, 32'd0);
      prev_stall = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc - cyc0;
      end
      if (mem_ce) ce_cnt++;
      if (mem_ce && mem_we) begin
        if (wq.size() == 0) check("wr_unexp", 1, 0);
        else begin
          e = wq.pop_front();
          check("wr_addr", {24'b0, mem_addr}, {24'b0, e[23:16]});
          check("wr_data", {16'b0, mem_din}, {16'b0, e[15:0]});
        end
      end
      if (mem_ce && !mem_we) begin
        check("occupancy", (iss_cnt - pop_cnt + 1
              - int'(rd_valid && rd_ready)) <= 2, 1);
        if (raq.size() == 0) check("rd_unexp", 1, 0);
        else check("rd_addr", {24'b0, mem_addr}, {24'b0, raq.pop_front()});
        iss_cnt++;
      end
      if (rd_valid) begin
        if (first_rv < 0) first_rv = cyc - cyc0;
        if (prev_stall) check("rd_stable", {16'b0, rd_data}, {16'b0, prev_data});
        if (rd_ready) begin
          pop_cnt++;
          if (rq.size() == 0) check("rd_unexp_pop", 1, 0);
          else check("rd_data", {16'b0, rd_data}, {16'b0, rq.pop_front()});
        end
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
    end
  end

  task automatic run_burst(input bit wr, input logic [7:0] a,
                           input logic [8:0] n, input logic [15:0] d0,
                           input int exp_done, input int exp_rv,
                           input bit poke);
    int base;
    int ce0;
    int guard;
    logic [7:0] ai;
    base     = done_cnt;
    ce0      = ce_cnt;
    first_rv = -1;
    if (!wr) begin
      for (int i = 0; i < int'(n); i++) begin
        ai = a + 8'(i);
        rq.push_back(shadow[ai]);
        raq.push_back(ai);
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = n;
    cyc0      = cyc;
    @(negedge clk);
    check("cmd_ready", {31'b0, cmd_ready}, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (poke) begin
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_len   = 9'd3;
      repeat (3) @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
    if (wr) begin
      for (int i = 0; i < int'(n); i++) begin
        ai       = a + 8'(i);
        wr_valid = 1'b1;
        wr_data  = d0 + 16'(i);
        wq.push_back({ai, wr_data});
        shadow[ai] = wr_data;
        @(negedge clk);
        check("wr_ready", {31'b0, wr_ready}, 1);
        @(posedge clk); #1;
      end
    end
    wr_valid = 1'b0;
    guard = 0;
    while (done_cnt == base && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    check("done_seen", {31'b0, done_cnt != base}, 1);
    @(posedge clk); #1;
    check("done_once", done_cnt - base, 1);
    if (exp_done >= 0) check("done_cyc", done_cyc, exp_done);
    if (exp_rv >= 0) check("first_rv", first_rv, exp_rv);
    check("ce_cnt", ce_cnt - ce0, {23'b0, n});
    check("wq_left", wq.size(), 0);
    check("rq_left", rq.size(), 0);
  endtask

  initial begin
    int base;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst", {25'b0, cmd_ready, wr_ready, rd_valid, busy,
                       done, mem_ce, mem_we}, 32'h40);

    run_burst(1'b1, 8'h10, 9'd4, 16'hA000, 5, -1, 1'b0);
    run_burst(1'b0, 8'h10, 9'd4, 16'h0, 7, 3, 1'b0);

    run_burst(1'b1, 8'h40, 9'd8, 16'hB000, 9, -1, 1'b0);
    rr_mode = 1;
    run_burst(1'b0, 8'h40, 9'd8, 16'h0, -1, -1, 1'b1);
    rr_mode = 0;

    run_burst(1'b1, 8'hFE, 9'd4, 16'hC000, 5, -1, 1'b0);
    run_burst(1'b0, 8'hFE, 9'd4, 16'h0, 7, 3, 1'b0);

    run_burst(1'b1, 8'h20, 9'd0, 16'h0, 1, -1, 1'b0);
    run_burst(1'b0, 8'h20, 9'd0, 16'h0, 1, -1, 1'b0);

    rr_mode = 2;
    @(posedge clk);
    base = done_cnt;
    for (int i = 0; i < 8; i++) begin
      rq.push_back(shadow[8'h40 + 8'(i)]);
      raq.push_back(8'h40 + 8'(i));
    end
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h40;
    cmd_len   = 9'd8;
    cyc0      = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_busy", {31'b0, busy}, 1);
    check("mid_rvalid", {31'b0, rd_valid}, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    rq.delete();
    raq.delete();
    iss_cnt = 0;
    pop_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rr_mode = 0;
    @(negedge clk);
    check("post_rst2", {25'b0, cmd_ready, wr_ready, rd_valid, busy,
                        done, mem_ce, mem_we}, 32'h40);
    check("no_done_rst", done_cnt - base, 0);
    run_burst(1'b0, 8'h40, 9'd2, 16'h0, 5, 3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
